// File: rtl/cmult_arbiter_if.sv
// Bundle between two requesters, the shared complex multiplier and the result consumer.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface cmult_arbiter_if #(
    parameter int W = 8
);
    logic                  req0_valid;
    logic                  req1_valid;
    logic                  req0_ready;
    logic                  req1_ready;
    logic signed [W-1:0]   req0_a_real;
    logic signed [W-1:0]   req0_a_imag;
    logic signed [W-1:0]   req0_b_real;
    logic signed [W-1:0]   req0_b_imag;
    logic signed [W-1:0]   req1_a_real;
    logic signed [W-1:0]   req1_a_imag;
    logic signed [W-1:0]   req1_b_real;
    logic signed [W-1:0]   req1_b_imag;
    logic signed [W-1:0]   m_a_real;
    logic signed [W-1:0]   m_a_imag;
    logic signed [W-1:0]   m_b_real;
    logic signed [W-1:0]   m_b_imag;
    logic [1:0]            mult_valid;
    logic signed [2*W-1:0] m_z_real;
    logic signed [2*W-1:0] m_z_imag;
    logic                  res_valid;
    logic                  res_id;
    logic signed [2*W-1:0] res_real;
    logic signed [2*W-1:0] res_imag;
    logic [15:0]           cnt0;
    logic [15:0]           cnt1;

    modport slave (
        input  req0_valid, req1_valid,
        input  req0_a_real, req0_a_imag, req0_b_real, req0_b_imag,
        input  req1_a_real, req1_a_imag, req1_b_real, req1_b_imag,
        input  m_z_real, m_z_imag,
        output req0_ready, req1_ready,
        output m_a_real, m_a_imag, m_b_real, m_b_imag, mult_valid,
        output res_valid, res_id, res_real, res_imag,
        output cnt0, cnt1
    );

    modport master (
        output req0_valid, req1_valid,
        output req0_a_real, req0_a_imag, req0_b_real, req0_b_imag,
        output req1_a_real, req1_a_imag, req1_b_real, req1_b_imag,
        output m_z_real, m_z_imag,
        input  req0_ready, req1_ready,
        input  m_a_real, m_a_imag, m_b_real, m_b_imag, mult_valid,
        input  res_valid, res_id, res_real, res_imag,
        input  cnt0, cnt1
    );
endinterface

// File: rtl/cmult_arbiter.sv
// Round-robin arbiter sharing one pipelined complex multiplier between two requesters;
// an id tag pipeline matched to the multiplier latency routes each product back to its owner.
module cmult_arbiter #(
    parameter int W        = 8,
    parameter int MULT_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    cmult_arbiter_if.slave   bus
);
    logic                grant0_s;
    logic                grant1_s;
    logic                accept_s;
    logic                last_grant_r;
    logic signed [W-1:0] a_real_r;
    logic signed [W-1:0] a_imag_r;
    logic signed [W-1:0] b_real_r;
    logic signed [W-1:0] b_imag_r;
    logic                issue_r;
    logic                issue_id_r;
    logic [MULT_LAT-1:0] tag_valid_r;
    logic [MULT_LAT-1:0] tag_id_r;
    logic [15:0]         cnt0_r;
    logic [15:0]         cnt1_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return 16'hFFFF;
        end else begin
            return value + 16'd1;
        end
    endfunction

    // Grant selection: contention goes to the requester not served last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (bus.req0_valid && bus.req1_valid) begin
            grant0_s = last_grant_r;
            grant1_s = ~last_grant_r;
        end else begin
            grant0_s = bus.req0_valid;
            grant1_s = bus.req1_valid;
        end
    end

    // A grant is only ever given to a valid requester, so grant equals acceptance.
    assign accept_s = grant0_s | grant1_s;

    // Round-robin pointer; reset favours requester 0 on first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            last_grant_r <= grant1_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Operand launch register and issue strobe towards the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_real_r   <= '0;
            a_imag_r   <= '0;
            b_real_r   <= '0;
            b_imag_r   <= '0;
            issue_r    <= 1'b0;
            issue_id_r <= 1'b0;
        end else begin
            issue_r    <= accept_s;
            issue_id_r <= grant1_s;
            if (accept_s) begin
                a_real_r <= grant1_s ? bus.req1_a_real : bus.req0_a_real;
                a_imag_r <= grant1_s ? bus.req1_a_imag : bus.req0_a_imag;
                b_real_r <= grant1_s ? bus.req1_b_real : bus.req0_b_real;
                b_imag_r <= grant1_s ? bus.req1_b_imag : bus.req0_b_imag;
            end
        end
    end

    // Tag pipeline aligned with the multiplier; reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_r <= '0;
            tag_id_r    <= '0;
        end else begin
            for (int i = MULT_LAT - 1; i > 0; i--) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_id_r[i]    <= tag_id_r[i-1];
            end
            tag_valid_r[0] <= issue_r;
            tag_id_r[0]    <= issue_id_r;
        end
    end

    // Per-requester acceptance counters, saturating rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_r <= 16'd0;
            cnt1_r <= 16'd0;
        end else begin
            if (grant0_s) begin
                cnt0_r <= sat_inc(cnt0_r);
            end
            if (grant1_s) begin
                cnt1_r <= sat_inc(cnt1_r);
            end
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;
    assign bus.m_a_real   = a_real_r;
    assign bus.m_a_imag   = a_imag_r;
    assign bus.m_b_real   = b_real_r;
    assign bus.m_b_imag   = b_imag_r;
    assign bus.mult_valid = {1'b0, issue_r};
    assign bus.res_valid  = tag_valid_r[MULT_LAT-1];
    assign bus.res_id     = tag_id_r[MULT_LAT-1];
    assign bus.res_real   = bus.m_z_real;
    assign bus.res_imag   = bus.m_z_imag;
    assign bus.cnt0       = cnt0_r;
    assign bus.cnt1       = cnt1_r;
endmodule

// File: tb/tb_cmult_arbiter.sv
// Bench for cmult_arbiter: a transaction-level model checks the MULT_LAT=2 instance every cycle;
// instances with MULT_LAT=1 and 4 share the stimulus for result-latency checks.
`timescale 1ns/1ps
module tb_cmult_arbiter;
    localparam int W  = 8;
    localparam int ML = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v0 = 1'b0;
    logic v1 = 1'b0;
    logic signed [W-1:0] a0r = '0, a0i = '0, b0r = '0, b0i = '0;
    logic signed [W-1:0] a1r = '0, a1i = '0, b1r = '0, b1i = '0;
    logic signed [2*W-1:0] zr_p [ML];
    logic signed [2*W-1:0] zi_p [ML];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : gx
            cmult_arbiter_if #(.W(W)) xb ();
            assign xb.req0_valid  = v0;
            assign xb.req1_valid  = v1;
            assign xb.req0_a_real = a0r;
            assign xb.req0_a_imag = a0i;
            assign xb.req0_b_real = b0r;
            assign xb.req0_b_imag = b0i;
            assign xb.req1_a_real = a1r;
            assign xb.req1_a_imag = a1i;
            assign xb.req1_b_real = b1r;
            assign xb.req1_b_imag = b1i;
            assign xb.m_z_real    = (g == 0) ? zr_p[ML-1] : '0;
            assign xb.m_z_imag    = (g == 0) ? zi_p[ML-1] : '0;
            cmult_arbiter #(.W(W), .MULT_LAT((g == 0) ? ML : ((g == 1) ? 1 : 4))) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (xb)
            );
        end
    endgenerate

    // Stand-in for the shared multiplier: product appears ML cycles after operands.
    always @(posedge clk) begin
        zr_p[0] <= gx[0].xb.m_a_real * gx[0].xb.m_b_real - gx[0].xb.m_a_imag * gx[0].xb.m_b_imag;
        zi_p[0] <= gx[0].xb.m_a_real * gx[0].xb.m_b_imag + gx[0].xb.m_a_imag * gx[0].xb.m_b_real;
        for (int i = 1; i < ML; i++) begin
            zr_p[i] <= zr_p[i-1];
            zi_p[i] <= zi_p[i-1];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction-level model state
    typedef struct {
        bit    id;
        int    re;
        int    im;
        int    due;
    } res_t;
    res_t q[$];
    bit   m_last = 1'b1;
    bit   m_mv   = 1'b0;
    int   m_ar = 0, m_ai = 0, m_br = 0, m_bi = 0;
    int   m_cnt0 = 0, m_cnt1 = 0;

    always @(negedge clk) begin
        bit   g0, g1;
        res_t r;
        g0 = !rst && v0 && (!v1 || m_last);
        g1 = !rst && v1 && (!v0 || !m_last);
        chk("req0_ready", gx[0].xb.req0_ready, g0);
        chk("req1_ready", gx[0].xb.req1_ready, g1);
        chk("mult_valid", gx[0].xb.mult_valid, {1'b0, m_mv});
        chk("m_a_real", gx[0].xb.m_a_real, m_ar);
        chk("m_a_imag", gx[0].xb.m_a_imag, m_ai);
        chk("m_b_real", gx[0].xb.m_b_real, m_br);
        chk("m_b_imag", gx[0].xb.m_b_imag, m_bi);
        chk("cnt0", gx[0].xb.cnt0, m_cnt0);
        chk("cnt1", gx[0].xb.cnt1, m_cnt1);
        if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            chk("res_valid", gx[0].xb.res_valid, 1);
            chk("res_id", gx[0].xb.res_id, r.id);
            chk("res_real", gx[0].xb.res_real, r.re);
            chk("res_imag", gx[0].xb.res_imag, r.im);
        end else begin
            chk("res_valid_idle", gx[0].xb.res_valid, 0);
        end
        if (rst) begin
            q.delete();
            m_last = 1'b1; m_mv = 1'b0;
            m_ar = 0; m_ai = 0; m_br = 0; m_bi = 0;
            m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            m_mv = g0 || g1;
            if (g0 || g1) begin
                m_ar = g1 ? int'(a1r) : int'(a0r);
                m_ai = g1 ? int'(a1i) : int'(a0i);
                m_br = g1 ? int'(b1r) : int'(b0r);
                m_bi = g1 ? int'(b1i) : int'(b0i);
                r.id  = g1;
                r.re  = m_ar * m_br - m_ai * m_bi;
                r.im  = m_ar * m_bi + m_ai * m_br;
                r.due = cyc + 1 + ML;
                q.push_back(r);
                m_last = g1;
            end
            if (g0 && m_cnt0 < 65535) m_cnt0++;
            if (g1 && m_cnt1 < 65535) m_cnt1++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Requests during reset are ignored.
        v0 = 1'b1; a0r = 8'sd9; a0i = 8'sd9; b0r = 8'sd9; b0i = 8'sd9;
        repeat (3) step();
        rst = 1'b0; v0 = 1'b0;
        @(negedge clk);
        chk("rst_cnt0", gx[0].xb.cnt0, 16'd0);
        chk("rst_mult_valid", gx[0].xb.mult_valid, 2'b00);

        // Single req0 transaction across three latencies.
        step();
        a0r = 8'sd1; a0i = 8'sd2; b0r = 8'sd3; b0i = 8'sd4; v0 = 1'b1;
        @(negedge clk);
        chk("t27_ready0", gx[0].xb.req0_ready, 1);
        for (int k = 1; k <= 6; k++) begin
            step();
            v0 = 1'b0;
            @(negedge clk);
            if (k == 1) begin
                chk("t27_mv", gx[0].xb.mult_valid, 2'b01);
                chk("t27_m", {gx[0].xb.m_a_real, gx[0].xb.m_a_imag, gx[0].xb.m_b_real, gx[0].xb.m_b_imag}, 32'h01020304);
            end
            if (k == 3) begin
                chk("t27_res_valid", gx[0].xb.res_valid, 1);
                chk("t27_res_id", gx[0].xb.res_id, 0);
                chk("t27_res_real", gx[0].xb.res_real, -32'sd5);
                chk("t27_res_imag", gx[0].xb.res_imag, 32'sd10);
                chk("t27_cnt0", gx[0].xb.cnt0, 16'd1);
            end
            chk("t32_lat1", gx[1].xb.res_valid, (k == 2));
            chk("t32_lat4", gx[2].xb.res_valid, (k == 5));
        end

        // Contention after reset alternates starting with requester 0.
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        a0r = 8'sd2; a0i = 8'sd4; b0r = 8'sd6; b0i = 8'sd8;
        a1r = 8'sd1; a1i = 8'sd3; b1r = 8'sd5; b1i = 8'sd7;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            v0 = 1'b1; v1 = 1'b1;
            @(negedge clk);
            chk("t28_grant0", gx[0].xb.req0_ready, (i % 2 == 0));
        end
        step(); v0 = 1'b0; v1 = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("t28_cnt0", gx[0].xb.cnt0, 16'd3);
        chk("t28_cnt1", gx[0].xb.cnt1, 16'd3);

        // Req1 alone streams without bubbles, then contention goes to req0.
        a1r = -8'sd3; a1i = 8'sd5; b1r = 8'sd7; b1i = -8'sd2;
        a0r = -8'sd128; a0i = 8'sd127; b0r = -8'sd128; b0i = -8'sd128;
        for (int i = 0; i < 4; i++) begin
            step(); v1 = 1'b1;
            @(negedge clk);
            chk("t29_ready1", gx[0].xb.req1_ready, 1);
        end
        step(); v0 = 1'b1;
        @(negedge clk);
        chk("t29_contend0", gx[0].xb.req0_ready, 1);
        chk("t29_contend1", gx[0].xb.req1_ready, 0);
        step(); v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        chk("t29_res_id", gx[0].xb.res_id, 1);
        chk("t29_res_real", gx[0].xb.res_real, -32'sd11);
        chk("t29_res_imag", gx[0].xb.res_imag, 32'sd41);
        repeat (6) step();

        // Reset with transactions in flight discards them.
        v0 = 1'b1;
        step(); v0 = 1'b0; v1 = 1'b1;
        step(); v1 = 1'b0; rst = 1'b1;
        step(); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t30_no_res", gx[0].xb.res_valid, 0);
            step();
        end
        @(negedge clk);
        chk("t30_mv", gx[0].xb.mult_valid, 2'b00);
        chk("t30_cnt", {gx[0].xb.cnt0, gx[0].xb.cnt1}, 32'd0);

        // Counter saturation.
        step(); v0 = 1'b1; a0r = 8'sd1; a0i = 8'sd0; b0r = 8'sd1; b0i = 8'sd0;
        repeat (65534) step();
        step(); v0 = 1'b0;
        @(negedge clk);
        chk("t31_sat", gx[0].xb.cnt0, 16'hFFFF);
        step(); v0 = 1'b1;
        repeat (3) step();
        v0 = 1'b0;
        @(negedge clk);
        chk("t31_hold", gx[0].xb.cnt0, 16'hFFFF);
        chk("t31_cnt1", gx[0].xb.cnt1, 16'd0);
        repeat (8) step();
        @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
